// File: rtl/spi_input_frontend.sv
// Input conditioning for the raw SPI slave pins: two-flop synchroniser, debounce
// filter and registered edge strobes for SCLK, CS and MOSI (channels 0, 1, 2).
module spi_input_frontend #(
  parameter int COUNTER_WIDTH = 3,
  parameter int WAIT_TIME     = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic sclk_pin,
  input  logic cs_pin,
  input  logic mosi_pin,
  output logic sclk_cond,
  output logic cs_cond,
  output logic mosi_cond,
  output logic sclk_posedge,
  output logic sclk_negedge,
  output logic cs_posedge,
  output logic cs_negedge
);

  if (WAIT_TIME < 1 || WAIT_TIME > (1 << COUNTER_WIDTH) - 1) begin : g_wait_time_check
    $error("spi_input_frontend: WAIT_TIME must be in 1 .. 2**COUNTER_WIDTH-1");
  end

  // CS idles high (deselected); SCLK and MOSI idle low.
  localparam logic [2:0] RESET_LEVEL = 3'b010;
  localparam logic [COUNTER_WIDTH-1:0] WAIT_CNT = WAIT_TIME[COUNTER_WIDTH-1:0];

  logic [2:0] pins;
  logic [2:0] sync0;
  logic [2:0] sync1;
  logic [2:0] cond;
  logic [2:0] accept;
  logic [1:0] rise;
  logic [1:0] fall;
  logic [COUNTER_WIDTH-1:0] cnt [3];

  assign pins = {mosi_pin, cs_pin, sclk_pin};

  always_comb begin
    accept = '0;
    for (int i = 0; i < 3; i++) begin
      accept[i] = (sync1[i] != cond[i]) && (cnt[i] == WAIT_CNT);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0 <= RESET_LEVEL;
      sync1 <= RESET_LEVEL;
      cond  <= RESET_LEVEL;
      cnt   <= '{default: '0};
      rise  <= '0;
      fall  <= '0;
    end else begin
      sync0 <= pins;
      sync1 <= sync0;
      rise  <= accept[1:0] & sync1[1:0];
      fall  <= accept[1:0] & ~sync1[1:0];
      for (int i = 0; i < 3; i++) begin
        if (sync1[i] == cond[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          cond[i] <= sync1[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign sclk_cond    = cond[0];
  assign cs_cond      = cond[1];
  assign mosi_cond    = cond[2];
  assign sclk_posedge = rise[0];
  assign sclk_negedge = fall[0];
  assign cs_posedge   = rise[1];
  assign cs_negedge   = fall[1];

endmodule

// File: tb/tb_spi_input_frontend.sv
// Bench for spi_input_frontend: two instances (WAIT_TIME 3 and 7) compared against a
// sliding-window model of the debounce rule, plus directed latency/glitch checks.
module tb_spi_input_frontend;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sclk_pin = 1'b0;
  logic cs_pin = 1'b1;
  logic mosi_pin = 1'b0;

  logic sclk_cond, cs_cond, mosi_cond, sclk_posedge, sclk_negedge, cs_posedge, cs_negedge;
  logic sclk_cond_7, cs_cond_7, mosi_cond_7, sclk_posedge_7, sclk_negedge_7, cs_posedge_7, cs_negedge_7;

  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  spi_input_frontend #(.COUNTER_WIDTH(3), .WAIT_TIME(3)) dut (
    .clk(clk), .reset(reset), .sclk_pin(sclk_pin), .cs_pin(cs_pin), .mosi_pin(mosi_pin),
    .sclk_cond(sclk_cond), .cs_cond(cs_cond), .mosi_cond(mosi_cond),
    .sclk_posedge(sclk_posedge), .sclk_negedge(sclk_negedge),
    .cs_posedge(cs_posedge), .cs_negedge(cs_negedge)
  );

  spi_input_frontend #(.COUNTER_WIDTH(3), .WAIT_TIME(7)) dut7 (
    .clk(clk), .reset(reset), .sclk_pin(sclk_pin), .cs_pin(cs_pin), .mosi_pin(mosi_pin),
    .sclk_cond(sclk_cond_7), .cs_cond(cs_cond_7), .mosi_cond(mosi_cond_7),
    .sclk_posedge(sclk_posedge_7), .sclk_negedge(sclk_negedge_7),
    .cs_posedge(cs_posedge_7), .cs_negedge(cs_negedge_7)
  );

  logic [6:0] obs3, obs7;
  assign obs3 = {sclk_cond, cs_cond, mosi_cond, sclk_posedge, sclk_negedge, cs_posedge, cs_negedge};
  assign obs7 = {sclk_cond_7, cs_cond_7, mosi_cond_7, sclk_posedge_7, sclk_negedge_7, cs_posedge_7, cs_negedge_7};

  localparam logic [6:0] IDLE_VEC = 7'b0100000;

  // Model: per instance and channel, a history of pin samples (index 0 = newest).
  // The level flips once the W+1 samples seen through the two-cycle synchroniser
  // delay all disagree with the current level.
  int wait_of[2] = '{3, 7};
  bit hist[2][3][16];
  bit mc[2][3];
  bit mpos[2][3];
  bit mneg[2][3];

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 3; c++) begin
        mc[d][c] = (c == 1);
        mpos[d][c] = 1'b0;
        mneg[d][c] = 1'b0;
        for (int k = 0; k < 16; k++) hist[d][c][k] = (c == 1);
      end
  endtask

  task automatic model_edge(input bit [2:0] p);
    bit all_differ;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 3; c++) begin
        for (int k = 15; k > 0; k--) hist[d][c][k] = hist[d][c][k-1];
        hist[d][c][0] = p[c];
        all_differ = 1'b1;
        for (int k = 0; k <= wait_of[d]; k++)
          if (hist[d][c][2+k] == mc[d][c]) all_differ = 1'b0;
        mpos[d][c] = 1'b0;
        mneg[d][c] = 1'b0;
        if (all_differ) begin
          mc[d][c] = ~mc[d][c];
          mpos[d][c] = mc[d][c];
          mneg[d][c] = ~mc[d][c];
        end
      end
  endtask

  function automatic logic [6:0] exp_vec(input int d);
    return {mc[d][0], mc[d][1], mc[d][2], mpos[d][0], mneg[d][0], mpos[d][1], mneg[d][1]};
  endfunction

  // Advance one clock; pins are only ever changed 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    if (!reset) model_edge({mosi_pin, cs_pin, sclk_pin});
    #1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      checks++;
      if (obs3 !== exp_vec(0) || obs7 !== exp_vec(1)) begin
        fails++;
        $display("FAIL settle: got %b/%b expected %b/%b", obs3, obs7, exp_vec(0), exp_vec(1));
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; sclk_pin = 1'b0; cs_pin = 1'b1; mosi_pin = 1'b0;
    model_reset();
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (obs3 !== IDLE_VEC || obs7 !== IDLE_VEC) begin
        fails++;
        $display("FAIL reset_idle cycle %0d: got %b/%b expected %b", i, obs3, obs7, IDLE_VEC);
      end
    end
  endtask

  task automatic test_sclk_latency();
    int n3, n7, pulses3;
    for (int dir = 1; dir >= 0; dir--) begin
      sclk_pin = dir[0];
      n3 = 0; n7 = 0; pulses3 = 0;
      for (int i = 1; i <= 20; i++) begin
        step();
        checks++;
        if (obs3 !== exp_vec(0) || obs7 !== exp_vec(1)) begin
          fails++;
          $display("FAIL sclk_model dir %0d edge %0d: got %b/%b expected %b/%b",
                   dir, i, obs3, obs7, exp_vec(0), exp_vec(1));
        end
        if ((dir == 1 ? sclk_posedge : sclk_negedge) === 1'b1) begin
          pulses3++;
          if (n3 == 0) n3 = i;
        end
        if ((dir == 1 ? sclk_posedge_7 : sclk_negedge_7) === 1'b1 && n7 == 0) n7 = i;
      end
      checks++;
      if (n3 != 6 || pulses3 != 1) begin
        fails++;
        $display("FAIL sclk_latency_w3 dir %0d: strobe at edge %0d x%0d, expected edge 6 x1", dir, n3, pulses3);
      end
      checks++;
      if (n7 != 10) begin
        fails++;
        $display("FAIL sclk_latency_w7 dir %0d: strobe at edge %0d, expected edge 10", dir, n7);
      end
      checks++;
      if (sclk_cond !== dir[0]) begin
        fails++;
        $display("FAIL sclk_level dir %0d: got %b expected %b", dir, sclk_cond, dir[0]);
      end
    end
  endtask

  task automatic test_cs_glitch();
    int neg3, pos3, ch3, any7;
    int widths[3] = '{2, 3, 4};
    for (int g = 0; g < 3; g++) begin
      neg3 = 0; pos3 = 0; ch3 = 0; any7 = 0;
      for (int i = 1; i <= 20; i++) begin
        cs_pin = (i <= widths[g]) ? 1'b0 : 1'b1;
        step();
        checks++;
        if (obs3 !== exp_vec(0) || obs7 !== exp_vec(1)) begin
          fails++;
          $display("FAIL cs_glitch_model width %0d edge %0d: got %b/%b expected %b/%b",
                   widths[g], i, obs3, obs7, exp_vec(0), exp_vec(1));
        end
        if (cs_negedge === 1'b1) neg3++;
        if (cs_posedge === 1'b1) pos3++;
        if (cs_cond !== 1'b1) ch3++;
        if (obs7 !== IDLE_VEC) any7++;
      end
      checks++;
      if (g < 2 && (neg3 != 0 || pos3 != 0 || ch3 != 0)) begin
        fails++;
        $display("FAIL cs_glitch_reject width %0d: neg %0d pos %0d low cycles %0d, expected 0/0/0",
                 widths[g], neg3, pos3, ch3);
      end
      if (g == 2 && (neg3 != 1 || pos3 != 1 || ch3 != 4)) begin
        fails++;
        $display("FAIL cs_glitch_accept width 4: neg %0d pos %0d low cycles %0d, expected 1/1/4",
                 neg3, pos3, ch3);
      end
      checks++;
      if (any7 != 0) begin
        fails++;
        $display("FAIL cs_glitch_w7 width %0d: %0d non-idle cycles, expected 0", widths[g], any7);
      end
    end
  endtask

  task automatic test_simultaneous();
    int both;
    both = 0;
    cs_pin = 1'b0; sclk_pin = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      checks++;
      if (obs3 !== exp_vec(0) || obs7 !== exp_vec(1)) begin
        fails++;
        $display("FAIL simul_model edge %0d: got %b/%b expected %b/%b", i, obs3, obs7, exp_vec(0), exp_vec(1));
      end
      if (cs_negedge === 1'b1 && sclk_posedge === 1'b1 && both == 0) both = i;
    end
    checks++;
    if (both != 6) begin
      fails++;
      $display("FAIL simul_strobes: joint strobe at edge %0d, expected edge 6", both);
    end
    cs_pin = 1'b1; sclk_pin = 1'b0;
    settle(14);
  endtask

  task automatic test_mosi_reset();
    int n3, n7;
    mosi_pin = 1'b1;
    step(); step(); step();
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (mosi_cond !== 1'b0 || obs3 !== IDLE_VEC || obs7 !== IDLE_VEC) begin
      fails++;
      $display("FAIL mosi_reset_immediate: got %b/%b expected %b", obs3, obs7, IDLE_VEC);
    end
    step(); step();
    reset = 1'b0;
    n3 = 0; n7 = 0;
    for (int i = 1; i <= 14; i++) begin
      step();
      checks++;
      if (obs3 !== exp_vec(0) || obs7 !== exp_vec(1)) begin
        fails++;
        $display("FAIL mosi_release_model edge %0d: got %b/%b expected %b/%b",
                 i, obs3, obs7, exp_vec(0), exp_vec(1));
      end
      if (mosi_cond === 1'b1 && n3 == 0) n3 = i;
      if (mosi_cond_7 === 1'b1 && n7 == 0) n7 = i;
    end
    checks++;
    if (n3 != 6 || n7 != 10) begin
      fails++;
      $display("FAIL mosi_release_latency: rose at edges %0d/%0d, expected 6/10", n3, n7);
    end
    mosi_pin = 1'b0;
    settle(14);
  endtask

  task automatic test_w7_hold();
    int rise7;
    int holds[2] = '{9, 7};
    for (int h = 0; h < 2; h++) begin
      rise7 = 0;
      for (int i = 1; i <= 24; i++) begin
        mosi_pin = (i <= holds[h]) ? 1'b1 : 1'b0;
        step();
        checks++;
        if (obs7 !== exp_vec(1)) begin
          fails++;
          $display("FAIL w7_hold_model hold %0d edge %0d: got %b expected %b", holds[h], i, obs7, exp_vec(1));
        end
        if (mosi_cond_7 === 1'b1 && rise7 == 0) rise7 = i;
      end
      checks++;
      if (rise7 != (h == 0 ? 10 : 0)) begin
        fails++;
        $display("FAIL w7_hold hold %0d: mosi_cond_7 rose at edge %0d, expected %0d",
                 holds[h], rise7, (h == 0 ? 10 : 0));
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(5) == 0) sclk_pin = ~sclk_pin;
      if ($urandom_range(7) == 0) cs_pin = ~cs_pin;
      if ($urandom_range(4) == 0) mosi_pin = ~mosi_pin;
      step();
      checks++;
      if (obs3 !== exp_vec(0) || obs7 !== exp_vec(1)) begin
        fails++;
        $display("FAIL random cycle %0d: got %b/%b expected %b/%b", i, obs3, obs7, exp_vec(0), exp_vec(1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_sclk_latency();
    test_cs_glitch();
    test_simultaneous();
    test_mosi_reset();
    test_w7_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
